// File: rtl/rng_roll_scheduler.sv
// Slot-machine style roller: seeds a 16-bit LFSR from a free-running counter on start,
// steps it at a rate that halves each stage, then freezes and pulses done. All outputs are registered.
module rng_roll_scheduler #(
  parameter int BASE_INTERVAL = 1_000_000,
  parameter int NUM_STAGES    = 8,
  parameter int STAGE_UPDATES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_stop,
  output logic [3:0] o_random_out,
  output logic [3:0] o_prev_out,
  output logic       o_busy,
  output logic       o_done
);

  localparam longint LAST_INTERVAL = longint'(BASE_INTERVAL) << (NUM_STAGES - 1);
  localparam int TW = $clog2(LAST_INTERVAL + 1);
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int UW = (STAGE_UPDATES > 1) ? $clog2(STAGE_UPDATES) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [UW-1:0] LAST_UPD   = UW'(STAGE_UPDATES - 1);

  typedef enum logic [1:0] {IDLE, ROLL, DONE} state_t;

  state_t        state;
  logic [15:0]   seed_cnt;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_last;
  logic [SW-1:0] stage;
  logic [UW-1:0] upd;

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  // Interval doubles every stage; the tick counter is sized for the slowest one.
  assign tick_last = (TW'(BASE_INTERVAL) << stage) - TW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      seed_cnt     <= 16'h0000;
      lfsr         <= 16'h0001;
      tick         <= '0;
      stage        <= '0;
      upd          <= '0;
      o_random_out <= 4'h0;
      o_prev_out   <= 4'h0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      seed_cnt <= seed_cnt + 16'd1;
      o_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state        <= ROLL;
            lfsr         <= (seed_cnt == 16'h0000) ? 16'h0001 : seed_cnt;
            o_prev_out   <= o_random_out;
            o_random_out <= 4'h0;
            tick         <= '0;
            upd          <= '0;
            stage        <= '0;
            o_busy       <= 1'b1;
          end
        end
        ROLL: begin
          // Early stop jumps to the slowest stage and swallows any coincident tick.
          if (i_stop) begin
            stage <= LAST_STAGE;
            upd   <= '0;
            tick  <= '0;
          end else if (tick == tick_last) begin
            lfsr         <= lfsr_next;
            o_random_out <= lfsr_next[3:0];
            tick         <= '0;
            if (upd == LAST_UPD) begin
              if (stage == LAST_STAGE) begin
                state  <= DONE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end else begin
                stage <= stage + SW'(1);
                upd   <= '0;
              end
            end else begin
              upd <= upd + UW'(1);
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
